score_keeper: RTL
=================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter HOLDOFF, default 4: clock cycles after an accepted Pass during which further Pass pulses are ignored (0 = no holdoff).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port Start  input  1  level; begins a game when in INITIAL.
REQ-005 SHALL have port Ack  input  1  level; acknowledges game over when in DONE.
REQ-006 SHALL have port Lose  input  1  level from collision logic; ends the game.
REQ-007 SHALL have port Pass  input  1  pulse, one per pipe cleared by the bird.
REQ-008 SHALL have port Score  output  16  current score as 4 packed BCD digits, [15:12] = thousands.
REQ-009 SHALL have port High  output  16  best score since reset as 4 packed BCD digits.
REQ-010 SHALL have port New_High  output  1  high in DONE when the last game set a new high score.
REQ-011 SHALL have ports q_Initial, q_Play, q_Done  output  1 each  one-hot state indicators.

Function
REQ-012 SHALL implement a 3-state FSM: INITIAL, PLAY, DONE; exactly one q_* output is high at any time.
REQ-013 INITIAL: Start=1 -> PLAY on the next edge; otherwise remain; Score held at 0.
REQ-014 PLAY: Lose=1 -> DONE on the next edge; Start and Ack ignored.
REQ-015 DONE: Ack=1 -> INITIAL on the next edge; Start ignored; Start=Ack=1 together -> INITIAL, never PLAY.
REQ-016 Pass SHALL be accepted only in PLAY with holdoff counter = 0; accepted Pass increments Score by 1 on the same edge (1-cycle latency).
REQ-017 On an accepted Pass, the holdoff counter SHALL load HOLDOFF, then decrement by 1 per cycle to 0; counter forced to 0 outside PLAY.
REQ-018 Increment SHALL be BCD: a digit at 9 wraps to 0 and carries into the next digit; no digit ever holds 10-15.
REQ-019 Score SHALL saturate at 9999: an accepted Pass at 9999 leaves Score at 9999.
REQ-020 Pass and Lose on the same PLAY edge: Pass SHALL count (if accepted) and FSM SHALL enter DONE on that edge.
REQ-021 On the first edge in DONE: if Score > High (BCD compare, thousands digit most significant), High <= Score and New_High <= 1; otherwise both unchanged.
REQ-022 Score SHALL hold its final value throughout DONE; cleared to 0 on the DONE->INITIAL edge.
REQ-023 New_High SHALL clear on the DONE->INITIAL edge; it is 0 in INITIAL and PLAY.
REQ-024 High SHALL persist across games; only reset clears it; equal score SHALL NOT set New_High.
REQ-025 Pass in INITIAL or DONE SHALL be ignored.

Reset
REQ-026 reset=1 at a rising edge SHALL force: state INITIAL (q_Initial=1, q_Play=0, q_Done=0), Score=0, High=0, New_High=0, holdoff counter=0.
REQ-027 reset SHALL take priority over all inputs, including mid-game and in DONE before the High update.
REQ-028 After reset deasserts, Start SHALL NOT be acted upon before the first edge with reset=0.

Verification
REQ-029 Reset; Start 1 cycle; 3 Pass pulses spaced 10 cycles apart -> Score=0x0003, q_Play=1; Lose -> q_Done=1, High=0x0003, New_High=1.
REQ-030 HOLDOFF=4, in PLAY: Pass high 6 consecutive cycles -> Score +2 (accepted at cycles 0 and 5).
REQ-031 Preload via 99 Pass pulses -> Score=0x0099; one more -> 0x0100; drive to 0x9999, one more Pass -> stays 0x9999.
REQ-032 Game 1 scores 5, Ack; game 2 scores 5 -> High=0x0005, New_High=0; game 3 scores 7 -> High=0x0007, New_High=1; Ack -> Score=0, New_High=0.
REQ-033 In DONE drive Start=Ack=1 one cycle -> q_Initial=1, next cycle (inputs low) remains INITIAL; Pass and Lose same cycle at Score=4 -> DONE with Score=5.
REQ-034 reset asserted mid-PLAY at Score=0x0012 with High=0x0030 -> next edge Score=0, High=0, q_Initial=1.

Source files
------------

// File: rtl/score_keeper.sv
// Score keeper for a pipe-dodging game: tracks the BCD score of the running
// game and the best score since reset, sequenced by an INITIAL/PLAY/DONE FSM.
module score_keeper #(
  parameter int HOLDOFF = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        Ack,
  input  logic        Lose,
  input  logic        Pass,
  output logic [15:0] Score,
  output logic [15:0] High,
  output logic        New_High,
  output logic        q_Initial,
  output logic        q_Play,
  output logic        q_Done
);

  // Holdoff counter must be able to hold HOLDOFF; keep at least one bit
  // so a zero holdoff still yields a legal vector.
  localparam int CntW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {
    INITIAL = 2'd0,
    PLAY    = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t          state_q;
  logic [15:0]     score_q;
  logic [15:0]     high_q;
  logic            newHigh_q;
  logic [CntW-1:0] holdoff_q;

  logic            passAccept;
  logic [15:0]     scoreInc_d;
  logic            carry;

  // A Pass counts only while playing and once the holdoff window has expired.
  always_comb begin
    passAccept = (state_q == PLAY) && Pass && (holdoff_q == '0);
  end

  // BCD increment of the score with saturation at 9999: ripple a carry from
  // the units digit upward, wrapping any 9 to 0.
  always_comb begin
    scoreInc_d = score_q;
    carry      = 1'b0;
    if (score_q != 16'h9999) begin
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (score_q[i*4 +: 4] == 4'd9) begin
            scoreInc_d[i*4 +: 4] = 4'd0;
          end else begin
            scoreInc_d[i*4 +: 4] = score_q[i*4 +: 4] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  // Game FSM together with score, high score, new-high flag and holdoff state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= INITIAL;
      score_q   <= 16'h0000;
      high_q    <= 16'h0000;
      newHigh_q <= 1'b0;
      holdoff_q <= '0;
    end else begin
      case (state_q)
        INITIAL: begin
          score_q   <= 16'h0000;
          newHigh_q <= 1'b0;
          holdoff_q <= '0;
          if (Start) begin
            state_q <= PLAY;
          end
        end
        PLAY: begin
          newHigh_q <= 1'b0;
          if (passAccept) begin
            score_q   <= scoreInc_d;
            holdoff_q <= CntW'(HOLDOFF);
          end else if (holdoff_q != '0) begin
            holdoff_q <= holdoff_q - CntW'(1);
          end
          if (Lose) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          holdoff_q <= '0;
          if (score_q > high_q) begin
            high_q <= score_q;
          end
          if (Ack) begin
            state_q   <= INITIAL;
            score_q   <= 16'h0000;
            newHigh_q <= 1'b0;
          end else if (score_q > high_q) begin
            newHigh_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= INITIAL;
          score_q   <= 16'h0000;
          newHigh_q <= 1'b0;
          holdoff_q <= '0;
        end
      endcase
    end
  end

  assign Score     = score_q;
  assign High      = high_q;
  assign New_High  = newHigh_q;
  assign q_Initial = (state_q == INITIAL);
  assign q_Play    = (state_q == PLAY);
  assign q_Done    = (state_q == DONE);

endmodule
